block_xfer_seq: RTL and testbench

BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

---
 rtl/block_xfer_seq.sv | 165 ++++++++++++++++
 tb/tb_block_xfer_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_xfer_seq.sv
// Block transfer sequencer: moves a list of registers to or from consecutive
// memory words, lowest register at the lowest address, with optional base
// register writeback of the final address.
module block_xfer_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    input  logic [3:0]  base_select,
    input  logic        up,
    input  logic        writeback,
    output logic [3:0]  read_B_select,
    output logic        read_B_en,
    input  logic [31:0] read_B_data,
    output logic [3:0]  write_select,
    output logic        write_en,
    output logic [31:0] write_data,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StXfer, StWb, StDone} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_list;
    logic        r_is_load;
    logic [3:0]  r_base_sel;
    logic        r_wb;
    logic        r_rn_in_list;
    logic [31:0] r_addr;
    logic [31:0] r_final;

    logic [4:0]  w_count;
    logic [31:0] w_span;
    logic [3:0]  w_cur_reg;
    logic [15:0] w_list_rest;
    logic        w_last;
    logic        w_do_wb;

    // Number of registers requested by the incoming list.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + {4'b0, reg_list[i]};
        end
    end

    assign w_span      = {25'b0, w_count, 2'b00};
    // Clearing the lowest set bit leaves the registers still to transfer.
    assign w_list_rest = r_list & (r_list - 16'd1);
    assign w_last      = (w_list_rest == 16'd0);
    // A load that overwrites Rn keeps the loaded value instead of the address.
    assign w_do_wb     = r_wb && !(r_is_load && r_rn_in_list);

    // Priority encoder: index of the lowest set bit still pending.
    always_comb begin
        w_cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur_reg = 4'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = (w_count == 5'd0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                if (mem_ack && w_last) begin
                    w_state_nxt = w_do_wb ? StWb : StDone;
                end
            end
            StWb:    w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Transfer context: latched on start, stepped on every memory ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_list       <= '0;
            r_is_load    <= 1'b0;
            r_base_sel   <= '0;
            r_wb         <= 1'b0;
            r_rn_in_list <= 1'b0;
            r_addr       <= '0;
            r_final      <= '0;
        end else if (r_state == StIdle && start) begin
            r_list       <= reg_list;
            r_is_load    <= is_load;
            r_base_sel   <= base_select;
            r_wb         <= writeback;
            r_rn_in_list <= reg_list[base_select];
            r_addr       <= up ? base_addr : base_addr - w_span;
            r_final      <= up ? base_addr + w_span : base_addr - w_span;
        end else if (r_state == StXfer && mem_ack) begin
            r_list <= w_list_rest;
            r_addr <= r_addr + 32'd4;
        end
    end

    // Bus outputs; everything idles at zero outside the active cases.
    always_comb begin
        read_B_select = '0;
        read_B_en     = 1'b0;
        write_select  = '0;
        write_en      = 1'b0;
        write_data    = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        busy          = (r_state != StIdle);
        done          = 1'b0;
        case (r_state)
            StXfer: begin
                mem_req  = 1'b1;
                mem_we   = !r_is_load;
                mem_addr = r_addr;
                if (!r_is_load) begin
                    read_B_en     = 1'b1;
                    read_B_select = w_cur_reg;
                    mem_wdata     = read_B_data;
                end else if (mem_ack) begin
                    write_en     = 1'b1;
                    write_select = w_cur_reg;
                    write_data   = mem_rdata;
                end
            end
            StWb: begin
                write_en     = 1'b1;
                write_select = r_base_sel;
                write_data   = r_final;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed bench for block_xfer_seq with a behavioural register bank and memory.
module tb_block_xfer_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  base_select;
    logic        up;
    logic        writeback;
    logic [3:0]  read_B_select;
    logic        read_B_en;
    logic [31:0] read_B_data;
    logic [3:0]  write_select;
    logic        write_en;
    logic [31:0] write_data;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [31:0] rf [16];
    logic [31:0] mem [256];

    int n_pass  = 0;
    int n_total = 0;

    assign read_B_data = rf[read_B_select];
    assign mem_rdata   = mem[mem_addr[9:2]];

    block_xfer_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .is_load      (is_load),
        .reg_list     (reg_list),
        .base_addr    (base_addr),
        .base_select  (base_select),
        .up           (up),
        .writeback    (writeback),
        .read_B_select(read_B_select),
        .read_B_en    (read_B_en),
        .read_B_data  (read_B_data),
        .write_select (write_select),
        .write_en     (write_en),
        .write_data   (write_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  sel;
        logic        up;
        logic        wb;
        int          delay;
        int          e_cycles;
        int          e_acc;
        logic [31:0] e_first;
        logic [31:0] e_last;
        logic [31:0] e_ldata;
        int          e_writes;
        logic [31:0] e_rn;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic init_state();
        for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 | 32'(i);
        for (int w = 0; w < 256; w++) mem[w] = 32'hD000_0000 | 32'(w);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cycles;
        int          acc;
        int          writes;
        int          wait_cnt;
        int          prev_reg;
        logic [31:0] prev_addr;
        logic [31:0] hold_addr;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
        logic [31:0] last_data;
        logic [3:0]  cur_reg;
        bit          order_ok;
        bit          stable_ok;
        bit          busy_ok;
        bit          done_seen;
        cycles = 0; acc = 0; writes = 0; wait_cnt = 0; prev_reg = -1;
        prev_addr = '0; hold_addr = '0; first_addr = '0; last_addr = '0; last_data = '0;
        order_ok = 1'b1; stable_ok = 1'b1; busy_ok = 1'b1; done_seen = 1'b0;
        init_state();
        @(negedge clk);
        is_load = v.is_load; reg_list = v.list; base_addr = v.base;
        base_select = v.sel; up = v.up; writeback = v.wb; start = 1'b1;
        @(posedge clk);
        while (!done_seen && cycles < 300) begin
            @(negedge clk);
            cycles++;
            // Re-raise start once mid-transfer; it must be ignored.
            start = (cycles == 1);
            // Stray acks outside XFER must be ignored too.
            mem_ack = mem_req ? (wait_cnt >= v.delay) : 1'b1;
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mem_req) begin
                if (wait_cnt > 0 && mem_addr !== hold_addr) stable_ok = 1'b0;
                if (!mem_ack) begin
                    hold_addr = mem_addr;
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (mem_we !== !v.is_load) order_ok = 1'b0;
                    if (mem_we) begin
                        if (!read_B_en) order_ok = 1'b0;
                        cur_reg   = read_B_select;
                        last_data = mem_wdata;
                        mem[mem_addr[9:2]] = mem_wdata;
                    end else begin
                        if (!write_en) order_ok = 1'b0;
                        cur_reg   = write_select;
                        last_data = write_data;
                    end
                    if (int'(cur_reg) <= prev_reg) order_ok = 1'b0;
                    if (acc > 0 && mem_addr !== prev_addr + 32'd4) order_ok = 1'b0;
                    if (acc == 0) first_addr = mem_addr;
                    prev_reg  = int'(cur_reg);
                    prev_addr = mem_addr;
                    last_addr = mem_addr;
                    acc++;
                end
            end
            if (write_en) begin
                writes++;
                rf[write_select] = write_data;
            end
            if (done) done_seen = 1'b1;
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        chk($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(v.e_cycles));
        chk($sformatf("v%0d_accesses", idx), 32'(acc), 32'(v.e_acc));
        chk($sformatf("v%0d_first_addr", idx), first_addr, v.e_first);
        chk($sformatf("v%0d_last_addr", idx), last_addr, v.e_last);
        chk($sformatf("v%0d_last_data", idx), last_data, v.e_ldata);
        chk($sformatf("v%0d_writes", idx), 32'(writes), 32'(v.e_writes));
        chk($sformatf("v%0d_rn", idx), rf[v.sel], v.e_rn);
        chk($sformatf("v%0d_order", idx), {31'b0, order_ok}, 32'd1);
        chk($sformatf("v%0d_addr_stable", idx), {31'b0, stable_ok}, 32'd1);
        chk($sformatf("v%0d_busy", idx), {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_back_idle", idx), {28'b0, busy, done, mem_req, write_en}, 32'd0);
    endtask

    initial begin
        bit clean;
        vecs[0] = '{1'b0, 16'h000B, 32'h100, 4'd13, 1'b1, 1'b1, 0,
                    5, 3, 32'h100, 32'h108, 32'hA000_0003, 1, 32'h10C};
        vecs[1] = '{1'b1, 16'h8001, 32'h200, 4'd2, 1'b0, 1'b1, 0,
                    4, 2, 32'h1F8, 32'h1FC, 32'hD000_007F, 3, 32'h1F8};
        vecs[2] = '{1'b1, 16'h0030, 32'h300, 4'd5, 1'b1, 1'b1, 0,
                    3, 2, 32'h300, 32'h304, 32'hD000_00C1, 2, 32'hD000_00C1};
        vecs[3] = '{1'b0, 16'h0000, 32'h40, 4'd1, 1'b1, 1'b1, 0,
                    1, 0, 32'h0, 32'h0, 32'h0, 0, 32'hA000_0001};
        vecs[4] = '{1'b0, 16'h0006, 32'h80, 4'd0, 1'b1, 1'b0, 3,
                    9, 2, 32'h80, 32'h84, 32'hA000_0002, 0, 32'hA000_0000};
        vecs[5] = '{1'b0, 16'h00F0, 32'h3F0, 4'd9, 1'b0, 1'b1, 1,
                    10, 4, 32'h3E0, 32'h3EC, 32'hA000_0007, 1, 32'h3E0};
        vecs[6] = '{1'b1, 16'h0001, 32'h0, 4'd3, 1'b0, 1'b1, 0,
                    3, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hD000_00FF, 2, 32'hFFFF_FFFC};

        init_state();
        reset_n = 1'b0; start = 1'b1; is_load = 1'b1; reg_list = 16'hFFFF;
        base_addr = 32'h1234; base_select = 4'd3; up = 1'b1; writeback = 1'b1; mem_ack = 1'b1;
        #12;
        chk("reset_outputs", {busy, done, mem_req, mem_we, write_en, read_B_en, 26'b0}, 32'd0);
        chk("reset_buses", mem_addr | mem_wdata | write_data
                           | {24'b0, read_B_select, write_select}, 32'd0);
        start = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #2; reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset pulsed during the second word of a store with writeback.
        init_state();
        @(negedge clk);
        is_load = 1'b0; reg_list = 16'h000F; base_addr = 32'h100;
        base_select = 4'd8; up = 1'b1; writeback = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        #1;
        chk("rst_pre_req", {31'b0, mem_req}, 32'd1);
        chk("rst_pre_addr", mem_addr, 32'h104);
        #1; reset_n = 1'b0; #1;
        chk("rst_async_req", {28'b0, mem_req, busy, read_B_en, write_en}, 32'd0);
        chk("rst_async_bus", mem_addr | mem_wdata | {28'b0, read_B_select}, 32'd0);
        mem_ack = 1'b1;
        clean = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (done || write_en || mem_req || busy) clean = 1'b0;
        end
        chk("rst_hold_quiet", {31'b0, clean}, 32'd1);
        chk("rst_no_wb", rf[8], 32'hA000_0008);
        mem_ack = 1'b0;
        @(posedge clk); #2; reset_n = 1'b1;
        run_vec(7, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
